// File: rtl/tri_pkg.sv
// Shared types and default sizing for the triangle-unit scheduler.
// Imported by tri_sched and its round-robin arbiter.
package tri_pkg;

  localparam int TRI_N       = 4;
  localparam int TRI_W       = 32;
  localparam int TRI_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } tri_state_e;

endpackage

// File: rtl/tri_sched_rr_arbiter.sv
// Combinational N-way round-robin picker.
// Search starts one past the last-granted index and wraps.
module rr_arbiter
  import tri_pkg::*;
#(
  parameter int N  = TRI_N,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_sched.sv
// Round-robin scheduler sharing one external triangle unit among N
// requesters, with a per-job timeout that returns an error response.
module tri_sched
  import tri_pkg::*;
#(
  parameter int N       = TRI_N,
  parameter int W       = TRI_W,
  parameter int TIMEOUT = TRI_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_arg,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [W-1:0]   acc_in0,
  output logic           acc_go,
  input  logic [W-1:0]   acc_out0,
  input  logic           acc_done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  tri_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [W-1:0]  arg_q, arg_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic          go_q, go_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  arb_gnt;
  logic [PW-1:0] win_idx;
  logic          take;
  logic          done_hit;
  logic          tmo_hit;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  assign take     = (state_q == ST_IDLE) && (|req) && !reset;
  assign done_hit = (state_q == ST_BUSY) && acc_done;
  assign tmo_hit  = (state_q == ST_BUSY) && !acc_done
                    && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take) state_d = ST_BUSY;
      ST_BUSY: if (done_hit || tmo_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    idx_d = idx_q;
    arg_d = arg_q;
    res_d = res_q;
    err_d = err_q;
    cnt_d = cnt_q;
    go_d  = (state_d == ST_BUSY);
    if (take) begin
      ptr_d = win_idx;
      idx_d = win_idx;
      arg_d = req_arg[int'(win_idx)*W +: W];
      cnt_d = '0;
    end
    if (state_q == ST_BUSY) begin
      if (done_hit) begin
        res_d = acc_out0;
        err_d = 1'b0;
      end else if (tmo_hit) begin
        res_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PW'(N - 1);
      idx_q <= '0;
      arg_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      go_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      arg_q <= arg_d;
      res_q <= res_d;
      err_q <= err_d;
      go_q  <= go_d;
      cnt_q <= cnt_d;
    end
  end

  // Strobes are suppressed while reset is asserted so an aborted job
  // never reports.
  always_comb begin
    grant     = '0;
    rsp_valid = '0;
    if (state_q == ST_IDLE && !reset) grant = arb_gnt;
    if (state_q == ST_RESP && !reset) rsp_valid[idx_q] = 1'b1;
    busy     = (state_q != ST_IDLE);
    acc_go   = go_q;
    acc_in0  = arg_q;
    rsp_data = res_q;
    rsp_err  = err_q;
  end

endmodule

// File: tb/tb_tri_sched.sv
// Scoreboard bench for tri_sched with a behavioural triangle-unit stub.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_tri_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_arg;
  logic [N-1:0]   grant;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [W-1:0]   acc_in0;
  logic           acc_go;
  logic [W-1:0]   acc_out0;
  logic           acc_done;

  always #5 clk = ~clk;

  tri_sched #(
    .N       (N),
    .W       (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_arg   (req_arg),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .acc_in0   (acc_in0),
    .acc_go    (acc_go),
    .acc_out0  (acc_out0),
    .acc_done  (acc_done)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Triangle-unit stub: done after stub_delay cycles of acc_go.
  int stub_delay = 1;
  bit stub_on    = 1'b1;
  bit spur       = 1'b0;
  int cyc        = 0;

  always @(posedge clk) begin
    if (reset || !acc_go) cyc <= 0;
    else                  cyc <= cyc + 1;
  end

  function automatic logic [W-1:0] tri_f(logic [W-1:0] n);
    logic [63:0] t;
    t = (64'(n) * (64'(n) + 64'd1)) / 64'd2;
    return t[W-1:0];
  endfunction

  assign acc_done = (stub_on && acc_go && (cyc == stub_delay - 1)) || spur;
  assign acc_out0 = tri_f(acc_in0);

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] d;
    logic         e;
  } rsp_t;

  logic [N-1:0] exp_g[$];
  rsp_t         exp_r[$];
  int           exp_len[$];

  task automatic push_job(logic [N-1:0] g, logic [W-1:0] d,
                          logic e, int len);
    rsp_t r;
    r.v = g;
    r.d = d;
    r.e = e;
    exp_g.push_back(g);
    exp_r.push_back(r);
    exp_len.push_back(len);
  endtask

  // Monitor
  int   run  = 0;
  int   gcnt = 0;
  rsp_t cur;

  always @(negedge clk) begin
    if (grant != '0) begin
      gcnt++;
      if (exp_g.size() == 0) chk("unexpected_grant", 64'(grant), 64'd0);
      else chk("grant", 64'(grant), 64'(exp_g.pop_front()));
    end
    if (rsp_valid != '0) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        cur = exp_r.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(cur.v));
        chk("rsp_data", 64'(rsp_data), 64'(cur.d));
        chk("rsp_err", 64'(rsp_err), 64'(cur.e));
        chk("go_low_in_resp", 64'(acc_go), 64'd0);
      end
    end
    if (acc_go) begin
      run++;
    end else if (run > 0) begin
      if (exp_len.size() == 0) chk("unexpected_go_run", 64'(run), 64'd0);
      else chk("go_len", 64'(run), 64'(exp_len.pop_front()));
      run = 0;
    end
  end

  // Requester model: drop req after seeing grant.
  bit           auto_drop = 1'b1;
  logic [N-1:0] gseen     = '0;

  always @(negedge clk) gseen = grant;

  always @(posedge clk) begin
    #1;
    if (auto_drop) req = req & ~gseen;
  end

  task automatic set_arg(int i, logic [W-1:0] v);
    req_arg[i*W +: W] = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_quiet(string name, int budget);
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_g.size() != 0 || busy || req != '0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_r.size() != 0 || exp_g.size() != 0 || busy || req != '0) begin
      total++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grants(int target, int budget);
    int n;
    n = 0;
    while (gcnt < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (gcnt < target) begin
      total++;
      $display("FAIL wait_grants: got %0d grants expected %0d", gcnt, target);
    end
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_arg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc_go", 64'(acc_go), 64'd0);
    chk("rst_acc_in0", 64'(acc_in0), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single job: arg 5, done after 5 cycles, result 15
    set_arg(0, 32'd5);
    stub_delay = 5;
    push_job(4'b0001, 32'd15, 1'b0, 5);
    @(posedge clk);
    #1 req = 4'b0001;
    wait_quiet("single", 60);

    // All four at once from fresh pointer: order 0,1,2,3
    do_reset();
    set_arg(0, 32'd1);
    set_arg(1, 32'd2);
    set_arg(2, 32'd3);
    set_arg(3, 32'd4);
    stub_delay = 3;
    push_job(4'b0001, 32'd1, 1'b0, 3);
    push_job(4'b0010, 32'd3, 1'b0, 3);
    push_job(4'b0100, 32'd6, 1'b0, 3);
    push_job(4'b1000, 32'd10, 1'b0, 3);
    @(posedge clk);
    #1 req = 4'b1111;
    wait_quiet("all_four", 100);

    // req0 and req2 held: grants alternate 0,2,0,2
    auto_drop = 1'b0;
    set_arg(0, 32'd3);
    set_arg(2, 32'd4);
    stub_delay = 2;
    push_job(4'b0001, 32'd6, 1'b0, 2);
    push_job(4'b0100, 32'd10, 1'b0, 2);
    push_job(4'b0001, 32'd6, 1'b0, 2);
    push_job(4'b0100, 32'd10, 1'b0, 2);
    @(posedge clk);
    #1 req = 4'b0101;
    wait_grants(gcnt + 4, 100);
    req       = '0;
    auto_drop = 1'b1;
    wait_quiet("alternate", 60);

    // Timeout: stub silent, 16 BUSY cycles then error response
    stub_on = 1'b0;
    set_arg(1, 32'd7);
    push_job(4'b0010, 32'd0, 1'b1, TMO);
    @(posedge clk);
    #1 req = 4'b0010;
    wait_quiet("timeout", 60);
    stub_on = 1'b1;

    // Spurious done in IDLE is ignored
    @(posedge clk);
    #1 spur = 1'b1;
    @(negedge clk);
    chk("spur_busy0", 64'(busy), 64'd0);
    @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    chk("spur_busy1", 64'(busy), 64'd0);
    chk("spur_go", 64'(acc_go), 64'd0);
    chk("spur_rsp", 64'(rsp_valid), 64'd0);

    // Reset 3 cycles into BUSY aborts silently
    set_arg(0, 32'd9);
    stub_delay = 10;
    exp_g.push_back(4'b0001);
    exp_len.push_back(3);
    @(posedge clk);
    #1 req = 4'b0001;
    wait_grants(gcnt + 1, 20);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_go", 64'(acc_go), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);

    // After reset, req0 and req3 together: 0 first
    set_arg(0, 32'd11);
    set_arg(3, 32'd2);
    stub_delay = 2;
    push_job(4'b0001, 32'd66, 1'b0, 2);
    push_job(4'b1000, 32'd3, 1'b0, 2);
    @(posedge clk);
    #1 req = 4'b1001;
    wait_quiet("post_reset", 60);

    chk("left_grants", 64'(exp_g.size()), 64'd0);
    chk("left_rsps", 64'(exp_r.size()), 64'd0);
    chk("left_lens", 64'(exp_len.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
